// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon Says input path and game core.
// Holds the button FSM states, the 2-bit button codes and the one-hot encoder.
package simon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    HELD,
    RELEASE
  } knapp_state_t;

  localparam logic [1:0] KNAPP_CODE_0 = 2'b00;
  localparam logic [1:0] KNAPP_CODE_1 = 2'b01;
  localparam logic [1:0] KNAPP_CODE_2 = 2'b10;
  localparam logic [1:0] KNAPP_CODE_3 = 2'b11;

  typedef struct packed {
    logic       onehot;
    logic [1:0] code;
  } knapp_enc_t;

  // Anything other than exactly one button high reports onehot=0 and code 00.
  function automatic knapp_enc_t onehot4_encode(input logic [3:0] buttons);
    knapp_enc_t r;
    r.onehot = 1'b0;
    r.code   = KNAPP_CODE_0;
    case (buttons)
      4'b0001: begin r.onehot = 1'b1; r.code = KNAPP_CODE_0; end
      4'b0010: begin r.onehot = 1'b1; r.code = KNAPP_CODE_1; end
      4'b0100: begin r.onehot = 1'b1; r.code = KNAPP_CODE_2; end
      4'b1000: begin r.onehot = 1'b1; r.code = KNAPP_CODE_3; end
      default: begin r.onehot = 1'b0; r.code = KNAPP_CODE_0; end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/knapp_sync.sv
// Two-flop synchroniser for asynchronous level inputs, any width.
// Both stages clear on reset so the first synchronised value after reset is 0.
module knapp_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/knapp_encoder.sv
// Button conditioning for the Simon core: synchronise, debounce press and release,
// and turn one confirmed single-button press into a 2-bit code plus a strobe.
module knapp_encoder
  import simon_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] knapp_raw,
  input  logic       knapp_en,
  output logic [1:0] knapp_comb,
  output logic       knapp_valid,
  output logic       knapp_multi
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       s;
  logic [3:0]       snap, snap_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       comb_nxt;
  logic             valid_nxt, multi_nxt;
  knapp_state_t     state, state_nxt;
  knapp_enc_t       enc;

  knapp_sync #(.WIDTH(4)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (knapp_raw),
    .q   (s)
  );

  assign enc = onehot4_encode(snap);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      snap        <= '0;
      knapp_comb  <= KNAPP_CODE_0;
      knapp_valid <= 1'b0;
      knapp_multi <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      snap        <= snap_nxt;
      knapp_comb  <= comb_nxt;
      knapp_valid <= valid_nxt;
      knapp_multi <= multi_nxt;
    end
  end

  // The counter is compared before it is incremented, so it stops at CNT_MAX
  // and never wraps even when DEBOUNCE_CYCLES is a power of two.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    snap_nxt  = snap;
    comb_nxt  = knapp_comb;
    valid_nxt = 1'b0;
    multi_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (s != 4'b0000) begin
          snap_nxt  = s;
          cnt_nxt   = '0;
          state_nxt = PRESS;
        end
      end
      PRESS: begin
        if (s != snap) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_MAX) begin
          state_nxt = HELD;
          if (knapp_en) begin
            if (enc.onehot) begin
              comb_nxt  = enc.code;
              valid_nxt = 1'b1;
            end else begin
              multi_nxt = 1'b1;
            end
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HELD: begin
        if (s == 4'b0000) begin
          cnt_nxt   = '0;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (s != 4'b0000) begin
          state_nxt = HELD;
        end else if (cnt == CNT_MAX) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_knapp_encoder.sv
// Directed bench for knapp_encoder with DEBOUNCE_CYCLES=4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_knapp_encoder;

  logic       clk;
  logic       rst;
  logic [3:0] knapp_raw;
  logic       knapp_en;
  logic [1:0] knapp_comb;
  logic       knapp_valid;
  logic       knapp_multi;

  int checks   = 0;
  int failures = 0;
  int valid_cnt = 0;
  int multi_cnt = 0;
  int both_cnt  = 0;
  int v0, m0;

  knapp_encoder #(.DEBOUNCE_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .knapp_raw   (knapp_raw),
    .knapp_en    (knapp_en),
    .knapp_comb  (knapp_comb),
    .knapp_valid (knapp_valid),
    .knapp_multi (knapp_multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Running strobe tallies used by the scenario-level checks.
  always @(negedge clk) begin
    if (knapp_valid) valid_cnt++;
    if (knapp_multi) multi_cnt++;
    if (knapp_valid && knapp_multi) both_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] raw, input logic en, input int n);
    knapp_raw = raw;
    knapp_en  = en;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Edge e=0 is the first rising edge after raw was last driven.
  task automatic stepCheck(input string tag, input int n, input int vedge, input int medge);
    for (int e = 0; e < n; e++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("%s_valid_e%0d", tag, e), {31'd0, knapp_valid}, {31'd0, e == vedge});
      checkOutput($sformatf("%s_multi_e%0d", tag, e), {31'd0, knapp_multi}, {31'd0, e == medge});
    end
  endtask

  initial begin
    rst       = 1'b1;
    knapp_raw = 4'b0000;
    knapp_en  = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_comb", {30'd0, knapp_comb}, 32'd0);
    checkOutput("reset_valid", {31'd0, knapp_valid}, 32'd0);
    checkOutput("reset_multi", {31'd0, knapp_multi}, 32'd0);
    rst = 1'b0;
    applyStimulus(4'b0000, 1'b1, 3);

    $display("[TB] clean press 0100");
    knapp_raw = 4'b0100;
    stepCheck("clean", 20, 6, -1);
    checkOutput("clean_comb", {30'd0, knapp_comb}, 32'd2);
    applyStimulus(4'b0000, 1'b1, 10);

    $display("[TB] disabled press 0010");
    v0 = valid_cnt; m0 = multi_cnt;
    knapp_raw = 4'b0010;
    knapp_en  = 1'b0;
    stepCheck("dis", 10, -1, -1);
    applyStimulus(4'b0000, 1'b0, 10);
    checkOutput("dis_comb", {30'd0, knapp_comb}, 32'd2);
    checkOutput("dis_strobes", valid_cnt - v0 + multi_cnt - m0, 32'd0);
    knapp_en  = 1'b1;
    knapp_raw = 4'b0010;
    stepCheck("en", 10, 6, -1);
    checkOutput("en_comb", {30'd0, knapp_comb}, 32'd1);
    applyStimulus(4'b0000, 1'b1, 10);

    $display("[TB] bounce 0001");
    v0 = valid_cnt;
    applyStimulus(4'b0001, 1'b1, 2);
    applyStimulus(4'b0000, 1'b1, 1);
    checkOutput("bounce_quiet", valid_cnt - v0, 32'd0);
    knapp_raw = 4'b0001;
    stepCheck("bounce", 12, 6, -1);
    checkOutput("bounce_comb", {30'd0, knapp_comb}, 32'd0);
    applyStimulus(4'b0000, 1'b1, 10);

    $display("[TB] release glitch 1000");
    v0 = valid_cnt;
    applyStimulus(4'b1000, 1'b1, 10);
    applyStimulus(4'b0000, 1'b1, 2);
    applyStimulus(4'b1000, 1'b1, 1);
    applyStimulus(4'b0000, 1'b1, 10);
    checkOutput("glitch_count", valid_cnt - v0, 32'd1);
    checkOutput("glitch_comb", {30'd0, knapp_comb}, 32'd3);
    applyStimulus(4'b0010, 1'b1, 10);
    applyStimulus(4'b0000, 1'b1, 10);
    checkOutput("glitch_next_count", valid_cnt - v0, 32'd2);
    checkOutput("glitch_next_comb", {30'd0, knapp_comb}, 32'd1);

    $display("[TB] multi press 1001");
    m0 = multi_cnt;
    knapp_raw = 4'b1001;
    stepCheck("multi", 10, -1, 6);
    applyStimulus(4'b0000, 1'b1, 10);
    checkOutput("multi_count", multi_cnt - m0, 32'd1);
    checkOutput("multi_comb", {30'd0, knapp_comb}, 32'd1);

    $display("[TB] reset during press 0100");
    applyStimulus(4'b0100, 1'b1, 4);
    rst = 1'b1;
    #1;
    checkOutput("midrst_comb", {30'd0, knapp_comb}, 32'd0);
    checkOutput("midrst_valid", {31'd0, knapp_valid}, 32'd0);
    checkOutput("midrst_multi", {31'd0, knapp_multi}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    stepCheck("postrst", 12, 6, -1);
    checkOutput("postrst_comb", {30'd0, knapp_comb}, 32'd2);
    applyStimulus(4'b0000, 1'b1, 10);

    checkOutput("never_both", both_cnt, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/knapp_encoder.md
# knapp_encoder

Input conditioning stage directly upstream of the Simon Says game core. It takes four raw, asynchronous push-buttons, synchronises and debounces them, and encodes a single confirmed press into the 2-bit `knapp_comb` code the game core consumes. Each accepted press is marked by a one-cycle `knapp_valid` strobe. Illegal multi-button presses are flagged on `knapp_multi` and never produce a code.

## Interface
- `DEBOUNCE_CYCLES`, default 16: number of consecutive stable synchronised samples required to accept a press or a release. Legal range is 2..65535.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: width of the debounce counter. Derived; never overridden.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `knapp_raw` in 4: raw button levels, asynchronous to `clk`. High means pressed.
- `knapp_en` in 1: when low, the FSM still tracks buttons but `knapp_valid` and `knapp_multi` are suppressed.
- `knapp_comb` out 2: code of the last accepted press. Held until the next accepted press.
- `knapp_valid` out 1: one-cycle strobe; `knapp_comb` is new in the same cycle.
- `knapp_multi` out 1: one-cycle strobe; a debounced press had more than one button high.

## Operation
- Synchroniser: two flops per bit; `s` is the second stage. Both stages reset to 0.
- Encoding: `knapp_raw[0]`→00, `[1]`→01, `[2]`→10, `[3]`→11.
- FSM states and transitions:
  - **IDLE**: if `s != 0`, latch `s` into `snap`, clear `cnt`, go to PRESS.
  - **PRESS**:
    - If `s != snap`, go to IDLE (bounce rejected; no output).
    - Else if `cnt == DEBOUNCE_CYCLES-1`, go to HELD. If `snap` is one-hot, update `knapp_comb` and pulse `knapp_valid`; otherwise pulse `knapp_multi`. Pulses are gated by `knapp_en`. `knapp_comb` is never updated when `knapp_en` is low.
    - Else increment `cnt`.
  - **HELD**: if `s == 0`, clear `cnt` and go to RELEASE. Changes among nonzero values (extra buttons, rollover) are ignored.
  - **RELEASE**:
    - If `s != 0`, go to HELD (release bounce).
    - Else if `cnt == DEBOUNCE_CYCLES-1`, go to IDLE.
    - Else increment `cnt`.
- At most one `knapp_valid` or `knapp_multi` strobe per press/release cycle. The two are never high together.
- A new press is not considered until the release has been debounced.
- `cnt` saturates by construction: the compare is done before the increment, so it never wraps.
- Reset mid-operation: all state returns to reset values at once and any pending press is discarded. After reset deasserts, a button still held is treated as a fresh press and must debounce again.

## Timing
- Reset values: `knapp_comb`=00, `knapp_valid`=0, `knapp_multi`=0, FSM=IDLE, `cnt`=0, `snap`=0.
- All outputs are registered. There is no combinational path from input to output.
- Latency, with a clean press first sampled at edge 0 and D = `DEBOUNCE_CYCLES`:
  - `s` goes high after edge 1.
  - IDLE→PRESS at edge 2.
  - `knapp_valid` is high for exactly one cycle, between edge D+2 and edge D+3.
- Release latency: `s` goes to 0, then D+1 edges later the FSM is back in IDLE.
- A `knapp_en` change takes effect on the strobe registered at the same edge. It has no synchroniser; it is sourced from the core in the `clk` domain.

## Structure
- Shared package `simon_pkg`:
  - state enum `knapp_state_t` (IDLE, PRESS, HELD, RELEASE);
  - 2-bit code constants `KNAPP_CODE_0..3`;
  - function `onehot4_encode` (returns code plus one-hot flag).
- Sub-module `knapp_sync`: parameterised-width two-flop synchroniser with async active-high reset. It is reusable for other async inputs.
- The top of `knapp_encoder` holds the FSM, counter, `snap` register and output registers.

## Test plan
All scenarios use D=4.
- Clean press of `knapp_raw`=0100 held for 20 cycles, sampled at edge 0 → `knapp_valid` high only between edges 6 and 7, `knapp_comb`=10, `knapp_multi` stays 0.
- Bounce: 0001 for 2 cycles, 0000 for 1, then 0001 held → no strobe during the bounce; one valid strobe 4 cycles after the restart, `knapp_comb`=00.
- Multi-press: 1001 held for 10 cycles → `knapp_multi` pulses once, no `knapp_valid`, `knapp_comb` unchanged.
- Hold then release glitch: 1000 accepted; released for 2 cycles, 1000 for 1, then released for 10 → exactly one `knapp_valid` total (`knapp_comb`=11); a following 0010 press gives a second strobe with code 01.
- `knapp_en`=0 during a 0010 press → no strobes and `knapp_comb` unchanged; set `knapp_en`=1 and press again → normal strobe.
- Assert `rst` for 1 cycle while in PRESS with 0100 still held → outputs zero at once; after reset the press re-debounces and the strobe appears D+3 edges after release of reset.
